matrix_alu_seq: RTL and testbench

//  Sequential, parametrised successor of the coprocessor's combinational matrix ALU.

---
 rtl/matrix_alu_seq_pkg.sv | 28 ++
 rtl/matrix_alu_seq_mac_unit.sv | 59 +++++
 rtl/matrix_alu_seq.sv | 176 +++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_seq_pkg.sv
// Shared definitions for the sequential matrix ALU.
//   opcode_e : operation encodings (000 and 111 are illegal)
//   state_e  : controller states IDLE -> LOAD -> RUN -> DONE
//   idx()    : bit offset of element (r,c) in a flat N_MAX*N_MAX*W bus
package matrix_alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b011,
    OP_OPP = 3'b100,
    OP_TRN = 3'b101,
    OP_SCL = 3'b110
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  function automatic int unsigned idx(input int unsigned r, input int unsigned c,
                                      input int unsigned n_max, input int unsigned w);
    return (r * n_max + c) * w;
  endfunction

endpackage

// File: rtl/matrix_alu_seq_mac_unit.sv
// mac_unit: signed multiply-accumulate with clear/preload, plus range check
// of the running sum back to W bits.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   en           : update the accumulator with this cycle's sum
//   clear        : start a new sum from addend instead of the accumulator
//   addend       : preload value used when clear=1 (e.g. the A operand of add/sub)
//   a, b         : signed factors
//   result       : this cycle's sum reduced to W bits (wrap, or clamp if SATURATE_EN)
//   ovf          : this cycle's sum lies outside the signed W-bit range
// Build option: SATURATE_EN clamps out-of-range sums instead of wrapping.
module mac_unit #(
  parameter int W     = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clear,
  input  logic signed [ACC_W-1:0] addend,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic signed [W-1:0]     result,
  output logic                    ovf
);

  localparam int MAX_I = (1 << (W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-MAX_I - 1);

  logic signed [2*W-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;

  always_comb begin
    prod     = (2*W)'(a) * (2*W)'(b);
    prod_ext = ACC_W'(prod);
    acc_next = (clear ? addend : acc) + prod_ext;
    ovf      = (acc_next > MAX_V) || (acc_next < MIN_V);
`ifdef SATURATE_EN
    if (acc_next > MAX_V)
      result = MAX_V[W-1:0];
    else if (acc_next < MIN_V)
      result = MIN_V[W-1:0];
    else
      result = acc_next[W-1:0];
`else
    result = acc_next[W-1:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset)
      acc <= '0;
    else if (en)
      acc <= acc_next;
  end

endmodule

// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: sequential matrix ALU (add, sub, mul, opposite, transpose,
// scalar multiply) on signed n x n matrices, n = 1..N_MAX, through one MAC.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start                 : request, accepted only when idle and not on the done cycle
//   opcode, matrix_size   : operation and n, latched on accept
//   scalar                : signed factor for the scalar-multiply operation
//   A_flat, B_flat        : operands, element (r,c) at [(r*N_MAX+c)*W +: W]
//   C_flat                : result, same layout; cells outside n x n are 0
//   busy, done            : in progress / one-cycle completion pulse
//   overflow_flag, error  : some element left the W-bit range / illegal request
// Build option: SATURATE_EN clamps out-of-range elements instead of wrapping.
module matrix_alu_seq
  import matrix_alu_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int N_MAX = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [2:0]               opcode,
  input  logic [2:0]               matrix_size,
  input  logic [W-1:0]             scalar,
  input  logic [N_MAX*N_MAX*W-1:0] A_flat,
  input  logic [N_MAX*N_MAX*W-1:0] B_flat,
  output logic [N_MAX*N_MAX*W-1:0] C_flat,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow_flag,
  output logic                     error
);

  localparam int ACC_W = 2 * W + $clog2(N_MAX);
  localparam int FW    = N_MAX * N_MAX * W;
  localparam logic [2:0] NMAX3 = 3'(N_MAX);
  localparam logic signed [W-1:0] ONE = W'(1);

  state_e state, state_next;

  logic [2:0]        op_q, n_q, n_m1, r, c, k;
  logic signed [W-1:0] scl_q;
  logic [FW-1:0]     a_q, b_q, c_q;
  logic              ovf_q, err_q;
  logic              accept, is_mul, op_legal, req_legal, k_last, write, finish;
  logic signed [W-1:0] a_rc, a_cr, a_rk, b_rc, b_kc;
  logic signed [ACC_W-1:0] addend;
  logic signed [W-1:0] mac_a, mac_b, mac_result;
  logic              mac_ovf, mac_clear, mac_en;

  // done is registered and lags the DONE state by a cycle, so blocking
  // acceptance while done is high keeps a start on the done cycle from
  // being taken.
  assign accept    = (state == S_IDLE) && start && !done;
  assign n_m1      = n_q - 3'd1;
  assign is_mul    = (op_q == OP_MUL);
  assign k_last    = !is_mul || (k == n_m1);
  assign write     = (state == S_RUN) && k_last;
  assign finish    = write && (r == n_m1) && (c == n_m1);
  assign req_legal = op_legal && (n_q != 3'd0) && (n_q <= NMAX3);
  assign mac_en    = (state == S_RUN);
  assign mac_clear = !is_mul || (k == 3'd0);

  always_comb begin
    a_rc = a_q[idx(32'(r), 32'(c), N_MAX, W) +: W];
    a_cr = a_q[idx(32'(c), 32'(r), N_MAX, W) +: W];
    a_rk = a_q[idx(32'(r), 32'(k), N_MAX, W) +: W];
    b_rc = b_q[idx(32'(r), 32'(c), N_MAX, W) +: W];
    b_kc = b_q[idx(32'(k), 32'(c), N_MAX, W) +: W];
  end

  // Every operation is mapped onto addend + a*b so one datapath serves all.
  always_comb begin
    addend   = '0;
    mac_a    = '0;
    mac_b    = '0;
    op_legal = 1'b1;
    case (op_q)
      OP_ADD:  begin addend = ACC_W'(a_rc); mac_a = b_rc;  mac_b = ONE; end
      OP_SUB:  begin addend = ACC_W'(a_rc); mac_a = b_rc;  mac_b = '1;  end
      OP_MUL:  begin mac_a = a_rk;  mac_b = b_kc; end
      OP_OPP:  begin mac_a = a_rc;  mac_b = '1;   end
      OP_TRN:  begin mac_a = a_cr;  mac_b = ONE;  end
      OP_SCL:  begin mac_a = scl_q; mac_b = a_rc; end
      default: op_legal = 1'b0;
    endcase
  end

  mac_unit #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clock  (clock),
    .reset  (reset),
    .en     (mac_en),
    .clear  (mac_clear),
    .addend (addend),
    .a      (mac_a),
    .b      (mac_b),
    .result (mac_result),
    .ovf    (mac_ovf)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_LOAD;
      S_LOAD:  state_next = req_legal ? S_RUN : S_DONE;
      S_RUN:   if (finish) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q  <= '0;
      n_q   <= '0;
      scl_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      r     <= '0;
      c     <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= (state == S_LOAD) || (state == S_RUN);
      done <= (state == S_DONE);
      if (accept) begin
        op_q  <= opcode;
        n_q   <= matrix_size;
        scl_q <= scalar;
        a_q   <= A_flat;
        b_q   <= B_flat;
        c_q   <= '0;
        ovf_q <= 1'b0;
        err_q <= 1'b0;
        r     <= '0;
        c     <= '0;
        k     <= '0;
      end
      if (state == S_LOAD && !req_legal)
        err_q <= 1'b1;
      if (write) begin
        c_q[idx(32'(r), 32'(c), N_MAX, W) +: W] <= mac_result;
        if (mac_ovf)
          ovf_q <= 1'b1;
      end
      if (state == S_RUN) begin
        if (!k_last) begin
          k <= k + 3'd1;
        end else begin
          k <= '0;
          if (c == n_m1) begin
            c <= '0;
            r <= r + 3'd1;
          end else begin
            c <= c + 3'd1;
          end
        end
      end
    end
  end

  assign C_flat        = c_q;
  assign overflow_flag = ovf_q;
  assign error         = err_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
module tb_matrix_alu_seq;
  import matrix_alu_seq_pkg::*;

  localparam int W  = 8;
  localparam int NM = 5;
  localparam int FW = NM * NM * W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    opcode = '0;
  logic [2:0]    matrix_size = '0;
  logic [W-1:0]  scalar = '0;
  logic [FW-1:0] A_flat = '0;
  logic [FW-1:0] B_flat = '0;
  logic [FW-1:0] C_flat;
  logic          busy, done, overflow_flag, error;

  always #5 clock = ~clock;

  matrix_alu_seq #(.W(W), .N_MAX(NM)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .opcode        (opcode),
    .matrix_size   (matrix_size),
    .scalar        (scalar),
    .A_flat        (A_flat),
    .B_flat        (B_flat),
    .C_flat        (C_flat),
    .busy          (busy),
    .done          (done),
    .overflow_flag (overflow_flag),
    .error         (error)
  );

  typedef struct {
    logic [2:0]    op;
    int            n;
    int            scl;
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    int            cr;
    int            cc;
    int            cv;
    logic          ovf;
    logic          err;
  } vec_t;

  typedef struct {
    logic [FW-1:0] c;
    logic          ovf;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [FW-1:0] last_c  = '0;

  function automatic int el(input logic [FW-1:0] m, input int r, input int c);
    logic signed [W-1:0] t;
    t = m[(r * NM + c) * W +: W];
    return int'(t);
  endfunction

  function automatic logic [FW-1:0] put(input logic [FW-1:0] m, input int r, input int c,
                                        input int v);
    m[(r * NM + c) * W +: W] = v[W-1:0];
    return m;
  endfunction

  function automatic int ws(input int wrapped, input int saturated);
`ifdef SATURATE_EN
    return saturated;
`else
    return wrapped;
`endif
  endfunction

  function automatic logic [FW-1:0] rnd_mat();
    logic [FW-1:0] m;
    for (int i = 0; i < NM * NM; i++)
      m[i * W +: W] = W'($urandom);
    return m;
  endfunction

  // Reference: full-precision integer arithmetic per element, then range handling.
  function automatic exp_t model(input logic [2:0] op, input int n, input int scl,
                                 input logic [FW-1:0] a, input logic [FW-1:0] b);
    exp_t e;
    int   v;
    e.c   = '0;
    e.ovf = 1'b0;
    e.err = (op == 3'b000) || (op == 3'b111) || (n < 1) || (n > NM);
    e.lat = 2;
    if (e.err) return e;
    e.lat = (op == 3'b011) ? 2 + n * n * n : 2 + n * n;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        case (op)
          3'b001:  v = el(a, r, c) + el(b, r, c);
          3'b010:  v = el(a, r, c) - el(b, r, c);
          3'b011: begin
            v = 0;
            for (int kk = 0; kk < n; kk++) v += el(a, r, kk) * el(b, kk, c);
          end
          3'b100:  v = -el(a, r, c);
          3'b101:  v = el(a, c, r);
          default: v = scl * el(a, r, c);
        endcase
        if (v > 127 || v < -128) begin
          e.ovf = 1'b1;
`ifdef SATURATE_EN
          v = (v > 127) ? 127 : -128;
`endif
        end
        e.c = put(e.c, r, c, v);
      end
    end
    return e;
  endfunction

  task automatic chk_int(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] op, input int n, input int scl,
                        input logic [FW-1:0] a, input logic [FW-1:0] b);
    opcode      = op;
    matrix_size = 3'(n);
    scalar      = W'(scl);
    A_flat      = a;
    B_flat      = b;
    start       = 1'b1;
    sb.push_back(model(op, n, scl, a, b));
  endtask

  // Called #1 after the accepting edge; optionally pulses start at cycle 'poke'.
  task automatic finish_op(input int poke, input string tag);
    exp_t e;
    int   cnt;
    logic seen;
    start       = 1'b0;
    A_flat      = rnd_mat();
    B_flat      = rnd_mat();
    scalar      = W'($urandom);
    opcode      = 3'($urandom);
    matrix_size = 3'($urandom);
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 400) begin
      @(posedge clock);
      #1;
      cnt++;
      start = 1'b0;
      if (cnt == 1) chk_int({tag, "_busy_t1"}, int'(busy), 1);
      if (done) seen = 1'b1;
      else if (cnt == poke) start = 1'b1;
    end
    start = 1'b0;
    if (!seen) chk_int({tag, "_timeout"}, cnt, -1);
    if (sb.size() == 0) begin
      chk_int({tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk_int({tag, "_latency"}, cnt, e.lat);
      chk_vec({tag, "_C"}, C_flat, e.c);
      chk_int({tag, "_ovf"}, int'(overflow_flag), int'(e.ovf));
      chk_int({tag, "_err"}, int'(error), int'(e.err));
      chk_int({tag, "_busy_at_done"}, int'(busy), 0);
      last_c = e.c;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vec[13];
    logic [FW-1:0] m1, m2;
    int            pulses;

    m1 = put(put('0, 0, 0, -28), 0, 1, 2);
    m2 = put('0, 0, 1, 2);
    vec[0]  = '{OP_ADD, 5, 0, m1, m2, 0, 1, 4, 1'b0, 1'b0};
    m1 = put(put(put(put('0, 0, 0, 1), 0, 1, 2), 1, 0, 3), 1, 1, 4);
    m2 = put(put('0, 0, 0, 1), 1, 1, 1);
    vec[1]  = '{OP_MUL, 2, 0, m1, m2, 1, 0, 3, 1'b0, 1'b0};
    m1 = put(put('0, 0, 0, 100), 0, 1, 100);
    m2 = put(put('0, 0, 0, 1), 1, 0, 1);
    vec[2]  = '{OP_MUL, 2, 0, m1, m2, 0, 0, ws(-56, 127), 1'b1, 1'b0};
    m1 = put(put('0, 1, 1, -128), 0, 0, 5);
    vec[3]  = '{OP_OPP, 3, 0, m1, '0, 1, 1, ws(-128, 127), 1'b1, 1'b0};
    m1 = put(put(put('0, 0, 2, 7), 2, 0, -5), 1, 2, 9);
    vec[4]  = '{OP_TRN, 3, 0, m1, '0, 2, 0, 7, 1'b0, 1'b0};
    vec[5]  = '{OP_TRN, 3, 0, m1, '0, 0, 2, -5, 1'b0, 1'b0};
    m1 = put(put(put('0, 0, 1, 64), 4, 4, 9), 3, 3, -3);
    vec[6]  = '{OP_SCL, 4, 2, m1, '0, 0, 1, ws(-128, 127), 1'b1, 1'b0};
    vec[7]  = '{OP_SCL, 4, 0, m1, '0, 3, 3, 0, 1'b0, 1'b0};
    m1 = put('0, 0, 0, 5);
    vec[8]  = '{3'b111, 3, 0, m1, m1, 0, 0, 0, 1'b0, 1'b1};
    vec[9]  = '{OP_ADD, 0, 0, m1, m1, 0, 0, 0, 1'b0, 1'b1};
    vec[10] = '{OP_ADD, 6, 0, m1, m1, 0, 0, 0, 1'b0, 1'b1};
    vec[11] = '{3'b000, 2, 0, m1, m1, 0, 0, 0, 1'b0, 1'b1};
    m1 = put('0, 0, 0, -128);
    m2 = put('0, 0, 0, 1);
    vec[12] = '{OP_SUB, 1, 0, m1, m2, 0, 0, ws(127, -128), 1'b1, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    chk_vec("reset_C", C_flat, '0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    chk_int("reset_ovf", int'(overflow_flag), 0);
    chk_int("reset_err", int'(error), 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(posedge clock);
      @(negedge clock);
      launch(vec[i].op, vec[i].n, vec[i].scl, vec[i].a, vec[i].b);
      @(posedge clock);
      #1;
      finish_op(-1, $sformatf("row%0d", i));
      chk_int($sformatf("row%0d_elem", i), el(C_flat, vec[i].cr, vec[i].cc), vec[i].cv);
      chk_int($sformatf("row%0d_tbl_ovf", i), int'(overflow_flag), int'(vec[i].ovf));
      chk_int($sformatf("row%0d_tbl_err", i), int'(error), int'(vec[i].err));
    end

    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      launch(3'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
             int'($urandom_range(0, 255)) - 128, rnd_mat(), rnd_mat());
      @(posedge clock);
      #1;
      finish_op(-1, $sformatf("rnd%0d", i));
    end

    // start pulsed while busy: ignored, one done pulse, result held afterwards
    @(posedge clock);
    @(negedge clock);
    launch(OP_MUL, 2, 0, rnd_mat(), rnd_mat());
    @(posedge clock);
    #1;
    finish_op(3, "poke");
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (done || busy) pulses++;
    end
    chk_int("poke_no_second_op", pulses, 0);
    chk_vec("poke_C_held", C_flat, last_c);

    // start held across the done cycle: ignored there, accepted one cycle later
    @(posedge clock);
    @(negedge clock);
    launch(OP_ADD, 3, 0, rnd_mat(), rnd_mat());
    @(posedge clock);
    #1;
    finish_op(-1, "b2b_first");
    launch(OP_SUB, 2, 0, rnd_mat(), rnd_mat());
    @(posedge clock);
    #1;
    chk_int("done_one_cycle", int'(done), 0);
    @(posedge clock);
    #1;
    finish_op(-1, "b2b_second");

    // reset in the middle of an n=5 multiply, then a fresh operation
    @(posedge clock);
    @(negedge clock);
    launch(OP_MUL, 5, 0, rnd_mat(), rnd_mat());
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk_int("mid_mul_busy", int'(busy), 1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk_int("abort_busy", int'(busy), 0);
    chk_vec("abort_C", C_flat, '0);
    chk_int("abort_done", int'(done), 0);
    chk_int("abort_ovf", int'(overflow_flag), 0);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    launch(OP_ADD, 5, 0, rnd_mat(), rnd_mat());
    @(posedge clock);
    #1;
    finish_op(-1, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
